fifo_param: RTL and testbench

Parametrised synchronous FIFO: next-generation buffer for the digital-circuits library with configurable data width and depth. Independent read and write strobes allow one push and one pop per cycle, including both in the same cycle. The block adds occupancy count, programmable almost-full/almost-empty flags and optional sticky error flags. It sits between a data producer and consumer in one clock domain.

---
 rtl/fifo_param.sv | 123 ++++++++++++
 tb/tb_fifo_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : fifo_param
// Purpose  : Single-clock parametrised FIFO with count, almost flags and
//            optional sticky Overflow/Underflow (compiled when FIFO_ERR_EN set)
// Revision : 1.0
// ============================================================================
module fifo_param #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 32,
   parameter int AF_LEVEL = DEPTH - 4,
   parameter int AE_LEVEL = 4,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic [WIDTH-1:0] Input,
   input  logic             Write,
   input  logic             Read,
   input  logic             Err_Clear,
   output logic [WIDTH-1:0] Output,
   output logic             Valid,
   output logic             Empty,
   output logic             Full,
   output logic             Almost_Empty,
   output logic             Almost_Full,
   output logic [AW:0]      Count,
   output logic             Overflow,
   output logic             Underflow
);

   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
   localparam logic [AW:0] AF_THR  = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] AE_THR  = (AW+1)'(AE_LEVEL);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             valid_q, valid_d;
   logic             rd_ok, wr_ok;

   // Full: same index with opposite wrap bits
   assign Empty        = (wptr_q == rptr_q);
   assign Full         = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
   assign Almost_Empty = (count_q <= AE_THR);
   assign Almost_Full  = (count_q >= AF_THR);
   assign Count        = count_q;
   assign Output       = out_q;
   assign Valid        = valid_q;

   always_comb begin
      rd_ok   = Read & ~Empty;
      wr_ok   = Write & (~Full | rd_ok);
      wptr_d  = wr_ok ? (wptr_q + PTR_ONE) : wptr_q;
      rptr_d  = rd_ok ? (rptr_q + PTR_ONE) : rptr_q;
      out_d   = rd_ok ? mem_q[rptr_q[AW-1:0]] : out_q;
      valid_d = rd_ok;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + PTR_ONE;
         2'b01:   count_d = count_q - PTR_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   // Storage is deliberately left out of reset
   always_ff @(posedge CLK) begin
      if (wr_ok) begin
         mem_q[wptr_q[AW-1:0]] <= Input;
      end
   end

`ifdef FIFO_ERR_EN
   logic ovf_q, ovf_d;
   logic unf_q, unf_d;

   always_comb begin
      ovf_d = ovf_q | (Write & ~wr_ok);
      unf_d = unf_q | (Read & Empty);
      if (Err_Clear) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign Overflow  = ovf_q;
   assign Underflow = unf_q;
`else
   logic unused_err_clear;
   assign unused_err_clear = Err_Clear;
   assign Overflow         = 1'b0;
   assign Underflow        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_param
// Purpose  : Directed self-checking bench for fifo_param (DEPTH=32, WIDTH=8)
// Revision : 1.0
// ============================================================================
module tb_fifo_param;

   logic       CLK = 1'b0;
   logic       Reset_n;
   logic [7:0] Input;
   logic       Write, Read, Err_Clear;
   logic [7:0] Output;
   logic       Valid, Empty, Full, Almost_Empty, Almost_Full;
   logic [5:0] Count;
   logic       Overflow, Underflow;

   int total = 0;
   int bad   = 0;

`ifdef FIFO_ERR_EN
   localparam logic ERR = 1'b1;
`else
   localparam logic ERR = 1'b0;
`endif

   fifo_param dut (
      .CLK          (CLK),
      .Reset_n      (Reset_n),
      .Input        (Input),
      .Write        (Write),
      .Read         (Read),
      .Err_Clear    (Err_Clear),
      .Output       (Output),
      .Valid        (Valid),
      .Empty        (Empty),
      .Full         (Full),
      .Almost_Empty (Almost_Empty),
      .Almost_Full  (Almost_Full),
      .Count        (Count),
      .Overflow     (Overflow),
      .Underflow    (Underflow)
   );

   always #5 CLK = ~CLK;

   // One clock with the given strobes; returns 1 time unit after the edge
   task automatic step(input logic w, input logic r, input logic [7:0] d, input logic clr);
      Write = w; Read = r; Input = d; Err_Clear = clr;
      @(posedge CLK);
      #1;
      Write = 1'b0; Read = 1'b0; Err_Clear = 1'b0;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; Write = 0; Read = 0; Input = 8'h00; Err_Clear = 0;
      #2;
      total++; if (Empty !== 1'b1)        begin bad++; $display("FAIL rst_empty got=%b exp=1", Empty); end
      total++; if (Almost_Empty !== 1'b1) begin bad++; $display("FAIL rst_ae got=%b exp=1", Almost_Empty); end
      total++; if (Full !== 1'b0)         begin bad++; $display("FAIL rst_full got=%b exp=0", Full); end
      total++; if (Almost_Full !== 1'b0)  begin bad++; $display("FAIL rst_af got=%b exp=0", Almost_Full); end
      total++; if (Count !== 6'd0)        begin bad++; $display("FAIL rst_count got=%0d exp=0", Count); end
      total++; if (Valid !== 1'b0)        begin bad++; $display("FAIL rst_valid got=%b exp=0", Valid); end
      total++; if (Output !== 8'h00)      begin bad++; $display("FAIL rst_output got=%h exp=00", Output); end
      total++; if (Overflow !== 1'b0 || Underflow !== 1'b0)
         begin bad++; $display("FAIL rst_err got=%b%b exp=00", Overflow, Underflow); end
      @(posedge CLK); @(negedge CLK);
      Reset_n = 1'b1;
      @(posedge CLK); #1;
   endtask

   task automatic test_order();
      for (int i = 1; i <= 32; i++) step(1, 0, 8'(i), 0);
      total++; if (Full !== 1'b1 || Count !== 6'd32)
         begin bad++; $display("FAIL order_full got full=%b cnt=%0d exp full=1 cnt=32", Full, Count); end
      for (int i = 1; i <= 32; i++) begin
         step(0, 1, 8'h00, 0);
         total++; if (Valid !== 1'b1 || Output !== 8'(i))
            begin bad++; $display("FAIL order_rd%0d got v=%b d=%h exp v=1 d=%h", i, Valid, Output, 8'(i)); end
      end
      total++; if (Empty !== 1'b1 || Count !== 6'd0)
         begin bad++; $display("FAIL order_end got empty=%b cnt=%0d exp empty=1 cnt=0", Empty, Count); end
   endtask

   task automatic test_almost();
      for (int i = 1; i <= 28; i++) begin
         step(1, 0, 8'(i), 0);
         if (i == 4)  begin total++; if (Almost_Empty !== 1'b1) begin bad++; $display("FAIL ae_at4 got=%b exp=1", Almost_Empty); end end
         if (i == 5)  begin total++; if (Almost_Empty !== 1'b0) begin bad++; $display("FAIL ae_at5 got=%b exp=0", Almost_Empty); end end
         if (i == 27) begin total++; if (Almost_Full !== 1'b0)  begin bad++; $display("FAIL af_at27 got=%b exp=0", Almost_Full); end end
         if (i == 28) begin total++; if (Almost_Full !== 1'b1 || Count !== 6'd28)
            begin bad++; $display("FAIL af_at28 got af=%b cnt=%0d exp af=1 cnt=28", Almost_Full, Count); end end
      end
      for (int c = 27; c >= 0; c--) begin
         step(0, 1, 8'h00, 0);
         if (c == 27) begin total++; if (Almost_Full !== 1'b0) begin bad++; $display("FAIL af_drain27 got=%b exp=0", Almost_Full); end end
         if (c == 5)  begin total++; if (Almost_Empty !== 1'b0) begin bad++; $display("FAIL ae_drain5 got=%b exp=0", Almost_Empty); end end
         if (c == 4)  begin total++; if (Almost_Empty !== 1'b1 || Count !== 6'd4)
            begin bad++; $display("FAIL ae_drain4 got ae=%b cnt=%0d exp ae=1 cnt=4", Almost_Empty, Count); end end
      end
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < 32; i++) step(1, 0, 8'(i), 0);
      for (int k = 0; k < 40; k++) begin
         step(1, 1, 8'hAA, 0);
         total++; if (Count !== 6'd32 || Full !== 1'b1)
            begin bad++; $display("FAIL frw_cnt%0d got cnt=%0d full=%b exp cnt=32 full=1", k, Count, Full); end
         total++; if (Valid !== 1'b1 || Output !== ((k < 32) ? 8'(k) : 8'hAA))
            begin bad++; $display("FAIL frw_data%0d got v=%b d=%h exp v=1 d=%h", k, Valid, Output, (k < 32) ? 8'(k) : 8'hAA); end
      end
      for (int k = 0; k < 32; k++) begin
         step(0, 1, 8'h00, 0);
         total++; if (Output !== 8'hAA) begin bad++; $display("FAIL frw_drain%0d got=%h exp=aa", k, Output); end
      end
      total++; if (Empty !== 1'b1) begin bad++; $display("FAIL frw_empty got=%b exp=1", Empty); end
   endtask

   task automatic test_empty_rw();
      step(1, 1, 8'h55, 0);
      total++; if (Valid !== 1'b0 || Count !== 6'd1 || Empty !== 1'b0)
         begin bad++; $display("FAIL erw_first got v=%b cnt=%0d empty=%b exp v=0 cnt=1 empty=0", Valid, Count, Empty); end
      step(0, 1, 8'h00, 0);
      total++; if (Valid !== 1'b1 || Output !== 8'h55 || Count !== 6'd0)
         begin bad++; $display("FAIL erw_read got v=%b d=%h cnt=%0d exp v=1 d=55 cnt=0", Valid, Output, Count); end
   endtask

   task automatic test_errors();
      step(0, 0, 8'h00, 1);
      step(0, 1, 8'h00, 0);
      total++; if (Underflow !== ERR || Valid !== 1'b0 || Output !== 8'h55)
         begin bad++; $display("FAIL err_unf got u=%b v=%b d=%h exp u=%b v=0 d=55", Underflow, Valid, Output, ERR); end
      for (int i = 0; i < 32; i++) step(1, 0, 8'h80 + 8'(i), 0);
      step(1, 0, 8'hEE, 0);
      total++; if (Overflow !== ERR || Count !== 6'd32)
         begin bad++; $display("FAIL err_ovf got o=%b cnt=%0d exp o=%b cnt=32", Overflow, Count, ERR); end
      step(0, 0, 8'h00, 1);
      total++; if (Overflow !== 1'b0 || Underflow !== 1'b0)
         begin bad++; $display("FAIL err_clear got o=%b u=%b exp 0 0", Overflow, Underflow); end
      for (int i = 0; i < 32; i++) begin
         step(0, 1, 8'h00, 0);
         total++; if (Output !== 8'h80 + 8'(i))
            begin bad++; $display("FAIL err_data%0d got=%h exp=%h", i, Output, 8'h80 + 8'(i)); end
      end
      step(0, 1, 8'h00, 1);
      total++; if (Underflow !== 1'b0)
         begin bad++; $display("FAIL err_clr_prio got=%b exp=0", Underflow); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 10; i++) step(1, 0, 8'h10 + 8'(i), 0);
      step(1, 1, 8'h1A, 0);
      total++; if (Count !== 6'd10 || Valid !== 1'b1 || Output !== 8'h10)
         begin bad++; $display("FAIL mid_pre got cnt=%0d v=%b d=%h exp cnt=10 v=1 d=10", Count, Valid, Output); end
      #2;
      Reset_n = 1'b0;
      #1;
      total++; if (Count !== 6'd0 || Empty !== 1'b1 || Almost_Empty !== 1'b1 || Full !== 1'b0)
         begin bad++; $display("FAIL mid_flags got cnt=%0d e=%b ae=%b f=%b exp 0 1 1 0", Count, Empty, Almost_Empty, Full); end
      total++; if (Valid !== 1'b0 || Output !== 8'h00)
         begin bad++; $display("FAIL mid_out got v=%b d=%h exp v=0 d=00", Valid, Output); end
      @(posedge CLK); @(negedge CLK);
      Reset_n = 1'b1;
      @(posedge CLK); #1;
      total++; if (Empty !== 1'b1) begin bad++; $display("FAIL mid_empty got=%b exp=1", Empty); end
      step(1, 0, 8'h3C, 0);
      step(0, 1, 8'h00, 0);
      total++; if (Valid !== 1'b1 || Output !== 8'h3C || Empty !== 1'b1)
         begin bad++; $display("FAIL mid_rd got v=%b d=%h e=%b exp v=1 d=3c e=1", Valid, Output, Empty); end
   endtask

   initial begin
      test_reset();
      test_order();
      test_almost();
      test_full_rw();
      test_empty_rw();
      test_errors();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
